// File: rtl/adder_responder_pkg.sv
// ============================================================================
// adder_responder_pkg : shared widths and packing for the operand/result path
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_responder_pkg;

    localparam int WIDTH_DEFAULT = 4;
    localparam int DEPTH_DEFAULT = 2;
    localparam int CNT_W_DEFAULT = 8;

    typedef struct packed {
        logic                     carry;
        logic [WIDTH_DEFAULT-1:0] sum;
    } rsp_t;

    // b sits in the upper half so this lines up with the parent's pair bus
    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] b;
        logic [WIDTH_DEFAULT-1:0] a;
    } pair_t;

endpackage

`default_nettype wire

// File: rtl/adder_responder_if.sv
// ============================================================================
// adder_responder_if : request (operand pair) and response (sum/carry) channels
// Rev 1.0
// ============================================================================
`default_nettype none

interface adder_responder_if
    import adder_responder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             req_valid;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_carry;
    logic             rsp_ready;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry
    );
endinterface

`default_nettype wire

// File: rtl/adder_responder_fifo.sv
// ============================================================================
// adder_responder_fifo : DEPTH-entry circular response buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_responder_fifo #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              push_i,
    input  wire logic [DATA_W-1:0] data_i,
    input  wire logic              pop_i,
    output logic      [DATA_W-1:0] data_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [DATA_W-1:0] hold_q;
    logic              w_push, w_pop;

    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    // When empty, keep presenting the last head so the outputs never go X
    assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            hold_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (!empty_o) hold_q <= mem_q[rd_ptr_q];
            if (w_push) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/adder_responder.sv
// ============================================================================
// adder_responder : accepts (a,b) pairs, returns buffered registered sum/carry
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_responder
    import adder_responder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  wire logic [1:0]       clock_reset,
    adder_responder_if.slave      bus,
    output logic      [CNT_W-1:0] txn_count
);
    // Same layout as rsp_t, sized for this instance's WIDTH
    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] sum;
    } rsp_w_t;

    logic             clk;
    logic             rst_n;
    rsp_w_t           w_push_rsp;
    rsp_w_t           w_head;
    logic             w_full, w_empty, w_push, w_pop;
    logic             ready_q;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;

    assign clk   = clock_reset[0];
    assign rst_n = clock_reset[1];

    assign w_push_rsp = rsp_w_t'({1'b0, bus.req_a} + {1'b0, bus.req_b});

    // ready_q keeps req_ready low until the first edge after reset release
    assign bus.req_ready = ready_q & ~w_full;
    assign bus.rsp_valid = ~w_empty;
    assign bus.rsp_sum   = w_head.sum;
    assign bus.rsp_carry = w_head.carry;
    assign txn_count     = txn_count_q;

    assign w_push      = bus.req_valid & bus.req_ready;
    assign w_pop       = bus.rsp_valid & bus.rsp_ready;
    assign txn_count_d = w_push ? txn_count_q + 1'b1 : txn_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            txn_count_q <= '0;
        end else begin
            ready_q     <= 1'b1;
            txn_count_q <= txn_count_d;
        end
    end

    adder_responder_fifo #(
        .DATA_W (WIDTH + 1),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .data_i  (w_push_rsp),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_adder_responder.sv
// ============================================================================
// tb_adder_responder : directed + random stimulus against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adder_responder;
    localparam int W  = 4;
    localparam int D  = 2;
    localparam int CW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    clock_reset;
    logic [CW-1:0] txn_count;

    assign clock_reset = {rst_n, clk};

    adder_responder_if #(.WIDTH(W)) bus ();

    adder_responder #(
        .WIDTH (W),
        .DEPTH (D),
        .CNT_W (CW)
    ) dut (
        .clock_reset (clock_reset),
        .bus         (bus),
        .txn_count   (txn_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: queue of raw a+b values in acceptance order, plus accepted count
    int exp_q[$];
    int exp_txn = 0;
    bit exp_en  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_state();
        bit ev;
        bit er;
        ev = (exp_q.size() != 0);
        er = exp_en && (exp_q.size() < D);
        check_eq("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, ev});
        check_eq("req_ready", {31'd0, bus.req_ready}, {31'd0, er});
        check_eq("txn_count", {24'd0, txn_count}, exp_txn % 256);
        if (ev) begin
            check_eq("rsp_sum",   {28'd0, bus.rsp_sum},   exp_q[0] % 16);
            check_eq("rsp_carry", {31'd0, bus.rsp_carry}, exp_q[0] / 16);
        end
    endtask

    // Called at a negedge: check, drive, cross one posedge, update model
    task automatic step(input bit v, input int a, input int b, input bit rr);
        bit ev;
        bit er;
        int av;
        int bv;
        check_state();
        ev = (exp_q.size() != 0);
        er = exp_en && (exp_q.size() < D);
        av = a % 16;
        bv = b % 16;
        bus.req_valid = v;
        bus.req_a     = av[W-1:0];
        bus.req_b     = bv[W-1:0];
        bus.rsp_ready = rr;
        @(posedge clk);
        if (ev && rr) void'(exp_q.pop_front());
        if (v && er) begin
            exp_q.push_back(av + bv);
            exp_txn = (exp_txn + 1) % 256;
        end
        exp_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, {31'd0, bus.rsp_valid}, 0);
        check_eq({tag, "_ready"}, {31'd0, bus.req_ready}, 0);
        check_eq({tag, "_txn"},   {24'd0, txn_count},     0);
        check_eq({tag, "_sum"},   {28'd0, bus.rsp_sum},   0);
        check_eq({tag, "_carry"}, {31'd0, bus.rsp_carry}, 0);
    endtask

    // Assert reset between edges, hold it across one edge, release at a negedge
    task automatic pulse_reset();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        exp_txn = 0;
        exp_en  = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // First edge after release: req_ready still low before it
        step(0, 0, 0, 1);

        // Single request 3+4
        step(1, 3, 4, 1);
        check_eq("t1_sum",   {28'd0, bus.rsp_sum},   7);
        check_eq("t1_carry", {31'd0, bus.rsp_carry}, 0);
        step(0, 0, 0, 1);
        check_eq("t1_drained", {31'd0, bus.rsp_valid}, 0);
        check_eq("t1_txn",     {24'd0, txn_count},     1);

        // Overflow cases
        step(1, 9, 8, 1);
        check_eq("ovf1_sum",   {28'd0, bus.rsp_sum},   1);
        check_eq("ovf1_carry", {31'd0, bus.rsp_carry}, 1);
        step(1, 15, 15, 1);
        check_eq("ovf2_sum",   {28'd0, bus.rsp_sum},   14);
        check_eq("ovf2_carry", {31'd0, bus.rsp_carry}, 1);
        step(0, 0, 0, 1);

        // Backpressure: fill, third request ignored, then drain in order
        step(1, 1, 1, 0);
        step(1, 2, 2, 0);
        check_eq("bp_full_ready", {31'd0, bus.req_ready}, 0);
        check_eq("bp_head",       {28'd0, bus.rsp_sum},   2);
        step(1, 3, 3, 0);
        check_eq("bp_hold",       {28'd0, bus.rsp_sum},   2);
        step(1, 3, 3, 1);
        check_eq("bp_second",     {28'd0, bus.rsp_sum},   4);
        step(1, 3, 3, 1);
        check_eq("bp_third",      {28'd0, bus.rsp_sum},   6);
        step(0, 0, 0, 1);
        check_eq("bp_empty",      {31'd0, bus.rsp_valid}, 0);

        // Streaming at occupancy 1 through several pointer wraps
        step(1, 0, 1, 0);
        for (int k = 1; k <= 10; k++) step(1, k, 1, 1);
        step(0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
        end

        // Reset mid-operation with a full buffer
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 5, 5, 0);
        step(1, 6, 6, 0);
        pulse_reset();
        step(0, 0, 0, 0);
        check_eq("post_rst_ready", {31'd0, bus.req_ready}, 1);
        step(0, 0, 0, 1);

        // Counter wrap: 256 accepted requests bring txn_count back to 0
        for (int i = 0; i < 256; i++) begin
            step(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1);
        end
        step(0, 0, 0, 1);
        check_eq("txn_wrap", {24'd0, txn_count}, 0);
        step(1, 7, 7, 1);
        check_eq("wrap_sum", {28'd0, bus.rsp_sum}, 14);
        step(0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
